// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer in front of a word-only data RAM: alignment/range checks,
// load extraction with sign/zero extension, and read-modify-write for SB/SH.
module dmem_access_ctrl #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  input  logic [31:0] reqPc,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspRdata,
  output logic        rspErr,
  output logic [31:0] memAddr,
  output logic        memReadEnable,
  input  logic [31:0] memReadData,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  output logic [31:0] memPc
);

  localparam logic [32:0] MEM_LO = 33'(MEM_BASE);
  localparam logic [32:0] MEM_HI = 33'(MEM_BASE) + 33'(MEM_WORDS) * 33'd4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic [2:0]  funct3Q;
  logic        writeQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic [31:0] pcQ;

  logic        accept_c;
  logic        alignErr_c;
  logic        funct3Err_c;
  logic        rangeOk_c;
  logic        reqErr_c;
  logic [7:0]  byteSel_c;
  logic [15:0] halfSel_c;
  logic [31:0] loadData_c;
  logic [31:0] mergeData_c;

  assign reqReady = (state == IDLE) && rstn;
  assign accept_c = reqValid && reqReady;

  // Request legality, evaluated on the live request in IDLE
  always_comb begin
    alignErr_c  = 1'b0;
    funct3Err_c = 1'b0;
    unique case (reqFunct3)
      F3_B:         funct3Err_c = 1'b0;
      F3_H:         alignErr_c  = reqAddr[0];
      F3_W:         alignErr_c  = (reqAddr[1:0] != 2'b00);
      F3_BU:        funct3Err_c = reqWrite;
      F3_HU: begin
        funct3Err_c = reqWrite;
        alignErr_c  = reqAddr[0];
      end
      default:      funct3Err_c = 1'b1;
    endcase
    rangeOk_c = ({1'b0, reqAddr} >= MEM_LO) && ({1'b0, reqAddr} < MEM_HI);
    reqErr_c  = alignErr_c || funct3Err_c || !rangeOk_c;
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    byteSel_c   = memReadData[{addrQ[1:0], 3'b000} +: 8];
    halfSel_c   = memReadData[{addrQ[1], 4'b0000} +: 16];
    loadData_c  = memReadData;
    unique case (funct3Q)
      F3_B:    loadData_c = {{24{byteSel_c[7]}}, byteSel_c};
      F3_BU:   loadData_c = {24'h0, byteSel_c};
      F3_H:    loadData_c = {{16{halfSel_c[15]}}, halfSel_c};
      F3_HU:   loadData_c = {16'h0, halfSel_c};
      default: loadData_c = memReadData;
    endcase
    mergeData_c = memReadData;
    if (funct3Q == F3_B) begin
      mergeData_c[{addrQ[1:0], 3'b000} +: 8] = wdataQ[7:0];
    end else begin
      mergeData_c[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      funct3Q        <= 3'b000;
      writeQ         <= 1'b0;
      addrQ          <= 32'h0;
      wdataQ         <= 32'h0;
      pcQ            <= 32'h0;
      rspValid       <= 1'b0;
      rspRdata       <= 32'h0;
      rspErr         <= 1'b0;
      memAddr        <= 32'h0;
      memReadEnable  <= 1'b0;
      memWriteEnable <= 1'b0;
      memWriteData   <= 32'h0;
      memPc          <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            funct3Q <= reqFunct3;
            writeQ  <= reqWrite;
            addrQ   <= reqAddr;
            wdataQ  <= reqWdata;
            pcQ     <= reqPc;
            if (reqErr_c) begin
              state    <= RESP;
              rspValid <= 1'b1;
              rspErr   <= 1'b1;
              rspRdata <= 32'h0;
            end else begin
              rspErr  <= 1'b0;
              memAddr <= {reqAddr[31:2], 2'b00};
              if (reqWrite && (reqFunct3 == F3_W)) begin
                state          <= WR;
                memWriteEnable <= 1'b1;
                memWriteData   <= reqWdata;
                memPc          <= reqPc;
              end else begin
                state         <= RD;
                memReadEnable <= 1'b1;
              end
            end
          end
        end
        RD: begin
          memReadEnable <= 1'b0;
          if (writeQ) begin
            state          <= WR;
            memWriteEnable <= 1'b1;
            memWriteData   <= mergeData_c;
            memPc          <= pcQ;
          end else begin
            state    <= RESP;
            rspValid <= 1'b1;
            rspRdata <= loadData_c;
          end
        end
        WR: begin
          memWriteEnable <= 1'b0;
          state          <= RESP;
          rspValid       <= 1'b1;
          rspRdata       <= 32'h0;
        end
        RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random traffic checked
// against a byte-addressed memory model.
module tb_dmem_access_ctrl;

  localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        reqValid, reqReady, reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr, reqWdata, reqPc;
  logic        rspValid, rspReady, rspErr;
  logic [31:0] rspRdata;
  logic [31:0] memAddr, memReadData, memWriteData, memPc;
  logic        memReadEnable, memWriteEnable;

  int checks = 0;
  int failures = 0;
  int rdCnt = 0;
  int wrCnt = 0;
  logic bothHigh = 1'b0;

  logic [31:0] ram [MEM_WORDS];
  logic [7:0]  refMem [MEM_BYTES];

  dmem_access_ctrl #(.MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rstn(rstn),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWdata(reqWdata), .reqPc(reqPc),
    .rspValid(rspValid), .rspReady(rspReady), .rspRdata(rspRdata), .rspErr(rspErr),
    .memAddr(memAddr), .memReadEnable(memReadEnable), .memReadData(memReadData),
    .memWriteEnable(memWriteEnable), .memWriteData(memWriteData), .memPc(memPc)
  );

  always #5 clk = ~clk;

  // Word RAM stand-in: combinational read, level write sampled on the clock
  assign memReadData = ram[memAddr[11:2]];

  always @(posedge clk) begin
    if (memWriteEnable && (memAddr - MEM_BASE) < MEM_BYTES) ram[memAddr[11:2]] <= memWriteData;
    if (memReadEnable) rdCnt <= rdCnt + 1;
    if (memWriteEnable) wrCnt <= wrCnt + 1;
    if (memReadEnable && memWriteEnable) bothHigh <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request through the controller, compared against the byte model
  task automatic doReq(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output logic [31:0] wrData, output int wrLat);
    logic [63:0] off;
    int size, rd0, wr0, spin;
    logic        expErr;
    logic [31:0] expData, expWord, firstData;
    int expLat;
    off  = {32'h0, addr} - {32'h0, MEM_BASE};
    size = 1 << f3[1:0];
    expErr = 1'b0;
    if (f3 == 3'd3 || f3 > 3'd5) expErr = 1'b1;
    if (wr && f3[2]) expErr = 1'b1;
    if (!expErr && (addr % size) != 0) expErr = 1'b1;
    if ({32'h0, addr} < {32'h0, MEM_BASE} || off >= 64'(MEM_BYTES)) expErr = 1'b1;
    expData = 32'h0;
    expWord = 32'h0;
    if (!expErr && !wr) begin
      for (int i = 0; i < size; i++) expData = expData | (32'(refMem[off + 64'(i)]) << (8 * i));
      if (!f3[2] && size < 4 && expData[8 * size - 1])
        for (int i = 8 * size; i < 32; i++) expData[i] = 1'b1;
    end
    if (!expErr && wr) begin
      for (int i = 0; i < size; i++) refMem[off + 64'(i)] = wdata[8 * i +: 8];
      for (int i = 0; i < 4; i++) expWord[8 * i +: 8] = refMem[(off & ~64'd3) + 64'(i)];
    end
    expLat = expErr ? 1 : ((wr && size < 4) ? 3 : 2);

    rd0 = rdCnt;
    wr0 = wrCnt;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqFunct3 = f3;
    reqAddr = addr; reqWdata = wdata; reqPc = pc;
    spin = 0;
    while (!reqReady && spin < 20) begin @(negedge clk); spin++; end
    check("req_ready", 32'(reqReady), 32'd1);
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0; wrLat = 0; wrData = 32'h0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (memWriteEnable) begin
        wrLat = lat;
        wrData = memWriteData;
        check("wr_pc", memPc, pc);
        check("wr_addr", memAddr, addr & ~32'd3);
      end
      if (memReadEnable) check("rd_addr", memAddr, addr & ~32'd3);
      if (rspValid) break;
    end
    rdata = rspRdata;
    err = rspErr;
    firstData = rspRdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rspValid), 32'd1);
      check("hold_rdata", rspRdata, firstData);
      check("hold_ready", 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;

    check("rsp_err", 32'(err), 32'(expErr));
    check("rsp_rdata", rdata, expData);
    check("latency", 32'(lat), 32'(expLat));
    check("rd_cycles", 32'(rdCnt - rd0), (!expErr && !(wr && size == 4)) ? 32'd1 : 32'd0);
    check("wr_cycles", 32'(wrCnt - wr0), (!expErr && wr) ? 32'd1 : 32'd0);
    if (!expErr && wr) begin
      check("wr_data", wrData, expWord);
      check("wr_lat", 32'(wrLat), (size == 4) ? 32'd1 : 32'd2);
    end
  endtask

  initial begin
    logic [31:0] rd, wd, pc;
    logic        er;
    int          lt, wl, sel, wr0;
    logic [31:0] a;

    for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] = 32'h0;
    for (int i = 0; i < int'(MEM_BYTES); i++) refMem[i] = 8'h0;
    rstn = 1'b0; reqValid = 1'b0; rspReady = 1'b0; reqWrite = 1'b0;
    reqFunct3 = 3'b000; reqAddr = 32'h0; reqWdata = 32'h0; reqPc = 32'h0;
    #2;
    check("rst_reqReady", 32'(reqReady), 32'd0);
    check("rst_rspValid", 32'(rspValid), 32'd0);
    check("rst_rspErr", 32'(rspErr), 32'd0);
    check("rst_rdEn", 32'(memReadEnable), 32'd0);
    check("rst_wrEn", 32'(memWriteEnable), 32'd0);
    check("rst_rspRdata", rspRdata, 32'h0);
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_memWdata", memWriteData, 32'h0);
    check("rst_memPc", memPc, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1 check("post_rst_ready", 32'(reqReady), 32'd1);

    // SW, then SB read-modify-write, then readback
    doReq(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h100, 0, rd, er, lt, wd, wl);
    check("t1_wdata", wd, 32'hDEADBEEF);
    check("t1_wrlat", 32'(wl), 32'd1);
    check("t1_lat", 32'(lt), 32'd2);
    doReq(1'b1, 3'b000, 32'h12, 32'h00000055, 32'h104, 0, rd, er, lt, wd, wl);
    check("t2_wdata", wd, 32'hDE55BEEF);
    check("t2_lat", 32'(lt), 32'd3);
    doReq(1'b0, 3'b010, 32'h10, 32'h0, 32'h108, 0, rd, er, lt, wd, wl);
    check("t2_lw", rd, 32'hDE55BEEF);

    // Extraction and extension
    doReq(1'b0, 3'b000, 32'h13, 32'h0, 32'h10C, 0, rd, er, lt, wd, wl);
    check("t3_lb", rd, 32'hFFFFFFDE);
    doReq(1'b0, 3'b100, 32'h13, 32'h0, 32'h110, 0, rd, er, lt, wd, wl);
    check("t3_lbu", rd, 32'h000000DE);
    doReq(1'b0, 3'b001, 32'h10, 32'h0, 32'h114, 0, rd, er, lt, wd, wl);
    check("t3_lh", rd, 32'hFFFFBEEF);
    doReq(1'b0, 3'b101, 32'h12, 32'h0, 32'h118, 0, rd, er, lt, wd, wl);
    check("t3_lhu", rd, 32'h0000DE55);

    // Error requests never touch memory
    doReq(1'b0, 3'b010, 32'h11, 32'h0, 32'h11C, 0, rd, er, lt, wd, wl);
    check("t4_lw_mis", 32'(er), 32'd1);
    doReq(1'b1, 3'b001, 32'h13, 32'h1234, 32'h120, 0, rd, er, lt, wd, wl);
    check("t4_sh_mis", 32'(er), 32'd1);
    doReq(1'b0, 3'b010, MEM_BASE + 32'(MEM_BYTES), 32'h0, 32'h124, 0, rd, er, lt, wd, wl);
    check("t4_lw_oor", 32'(er), 32'd1);
    check("t4_oor_rdata", rd, 32'h0);

    // Backpressure: response held for 5 cycles
    doReq(1'b0, 3'b010, 32'h10, 32'h0, 32'h128, 5, rd, er, lt, wd, wl);
    check("t5_rdata", rd, 32'hDE55BEEF);
    @(negedge clk);
    check("t5_idle_ready", 32'(reqReady), 32'd1);
    doReq(1'b0, 3'b000, 32'h12, 32'h0, 32'h12C, 0, rd, er, lt, wd, wl);
    check("t5_next", rd, 32'h00000055);

    // Random traffic against the model
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 32'($urandom_range(0, 127));
      else if (sel < 8) a = MEM_BASE + 32'(MEM_BYTES) - 32'd8 + 32'($urandom_range(0, 15));
      else              a = $urandom;
      doReq(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
            $urandom_range(0, 2), rd, er, lt, wd, wl);
    end

    // Reset during the RD cycle of an SB: nothing written, no response
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b000;
    reqAddr = 32'h20; reqWdata = 32'h000000AA; reqPc = 32'h200;
    @(posedge clk);
    #1 reqValid = 1'b0;
    check("t6_in_rd", 32'(memReadEnable), 32'd1);
    wr0 = wrCnt;
    #2 rstn = 1'b0;
    #1;
    check("t6_rdEn_drop", 32'(memReadEnable), 32'd0);
    check("t6_wrEn_drop", 32'(memWriteEnable), 32'd0);
    check("t6_no_rsp", 32'(rspValid), 32'd0);
    check("t6_ready_low", 32'(reqReady), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("t6_no_write", 32'(wrCnt - wr0), 32'd0);
    check("t6_ready", 32'(reqReady), 32'd1);
    check("t6_no_rsp2", 32'(rspValid), 32'd0);
    doReq(1'b0, 3'b010, 32'h20, 32'h0, 32'h204, 0, rd, er, lt, wd, wl);

    check("never_both_enables", 32'(bothHigh), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
